// File: rtl/cpu_mem_bus_if.sv
// cpu_mem_bus_if: req/ack data-bus bundle between the MEM stage and the data memory.
//   bus_req   : access request, held until bus_ack
//   bus_we    : 1 = write, 0 = read
//   bus_addr  : word address, [1:0] always 0
//   bus_wdata : store data
//   bus_rdata : load data, valid with bus_ack
//   bus_ack   : access complete
// Modports: master (MEM stage side), slave (memory side).
interface cpu_mem_bus_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/cpu_mem_bus.sv
// cpu_mem_bus: memory stage of the PLP pipeline.
// Turns EX load/store control into a req/ack access on the data bus, stalls the pipeline
// while the access is outstanding and registers results (p_*) for writeback.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   cpu_stall         : external stall from other stages
//   ex_*              : EX pipeline register (control, ALU result, store data, rt, link)
//   wb_*              : writeback port, forwarded into store data
//   bus               : data bus (cpu_mem_bus_if.master)
//   mem_stall         : pipeline stall request
//   bus_err           : sticky timeout flag
//   p_*               : registered results to WB
// Optional: define MEM_TIMEOUT_EN to abort an access after TIMEOUT_CYCLES cycles without
// bus_ack; the load then returns ERR_DATA and bus_err sets until reset.
module cpu_mem_bus #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hdeadbeef
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_stall,
  input  logic                 ex_c_rfw,
  input  logic [1:0]           ex_c_wbsource,
  input  logic [1:0]           ex_c_drw,
  input  logic [31:0]          ex_alu_r,
  input  logic [31:0]          ex_rfb,
  input  logic [4:0]           ex_rf_waddr,
  input  logic [31:0]          ex_jalra,
  input  logic [4:0]           ex_rt,
  input  logic [31:0]          wb_wdata,
  input  logic                 wb_rfw,
  input  logic [4:0]           wb_waddr,
  cpu_mem_bus_if.master        bus,
  output logic                 mem_stall,
  output logic                 bus_err,
  output logic                 p_c_rfw,
  output logic [1:0]           p_c_wbsource,
  output logic [31:0]          p_alu_r,
  output logic [31:0]          p_mem_data,
  output logic [4:0]           p_rf_waddr,
  output logic [31:0]          p_jalra
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state;
  logic [31:0] hold;     // load data captured on ack, presented to WB from DONE
  logic [31:0] sd;
  logic        mem_op;
  logic        p_load;

  assign mem_op = (ex_c_drw != 2'b00);

  // A store whose data register is being written back this cycle takes the WB value.
  assign sd = (wb_rfw && (wb_waddr == ex_rt) && (wb_waddr != 5'd0)) ? wb_wdata : ex_rfb;

  assign mem_stall = (state == StAccess) || ((state == StIdle) && mem_op);
  assign p_load    = !mem_stall && !cpu_stall;

  // Address bits [1:0] are dropped: the bus is word addressed.
  logic [1:0] unused_alu_lsb;
  assign unused_alu_lsb = ex_alu_r[1:0];

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] tmo_cnt;
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = ERR_DATA ^ TIMEOUT_CYCLES;
  assign bus_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= StIdle;
      hold          <= '0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      p_c_rfw       <= 1'b0;
      p_c_wbsource  <= '0;
      p_alu_r       <= '0;
      p_mem_data    <= '0;
      p_rf_waddr    <= '0;
      p_jalra       <= '0;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt       <= '0;
      bus_err       <= 1'b0;
`endif
    end else begin
      if (p_load) begin
        p_c_rfw      <= ex_c_rfw;
        p_c_wbsource <= ex_c_wbsource;
        p_alu_r      <= ex_alu_r;
        p_rf_waddr   <= ex_rf_waddr;
        p_jalra      <= ex_jalra;
        // Non-memory instructions leave p_mem_data untouched.
        if (state == StDone) p_mem_data <= hold;
      end

      unique case (state)
        StIdle: begin
          if (mem_op) begin
            bus.bus_addr  <= {ex_alu_r[31:2], 2'b00};
            bus.bus_wdata <= sd;
            bus.bus_we    <= ex_c_drw[0];
            bus.bus_req   <= 1'b1;
            state         <= StAccess;
          end
        end
        StAccess: begin
          // Ack has priority over the timeout limit in the same cycle.
          if (bus.bus_ack) begin
            if (!bus.bus_we) hold <= bus.bus_rdata;
            bus.bus_req <= 1'b0;
            state       <= StDone;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt     <= '0;
          end else if (tmo_cnt == CntW'(TIMEOUT_CYCLES - 1)) begin
            hold        <= ERR_DATA;
            bus.bus_req <= 1'b0;
            bus_err     <= 1'b1;
            tmo_cnt     <= '0;
            state       <= StDone;
          end else begin
            tmo_cnt     <= tmo_cnt + 1'b1;
`endif
          end
        end
        StDone: begin
          if (!cpu_stall) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_bus.sv
module tb_cpu_mem_bus;

  localparam int unsigned TmoCycles = 4;
  localparam logic [31:0] ErrData   = 32'hdeadbeef;

  logic        clk, rst, cpu_stall;
  logic        ex_c_rfw;
  logic [1:0]  ex_c_wbsource, ex_c_drw;
  logic [31:0] ex_alu_r, ex_rfb, ex_jalra;
  logic [4:0]  ex_rf_waddr, ex_rt;
  logic [31:0] wb_wdata;
  logic        wb_rfw;
  logic [4:0]  wb_waddr;
  logic        mem_stall, bus_err;
  logic        p_c_rfw;
  logic [1:0]  p_c_wbsource;
  logic [31:0] p_alu_r, p_mem_data, p_jalra;
  logic [4:0]  p_rf_waddr;

  cpu_mem_bus_if bus ();

  cpu_mem_bus #(
    .TIMEOUT_CYCLES (TmoCycles),
    .ERR_DATA       (ErrData)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_stall     (cpu_stall),
    .ex_c_rfw      (ex_c_rfw),
    .ex_c_wbsource (ex_c_wbsource),
    .ex_c_drw      (ex_c_drw),
    .ex_alu_r      (ex_alu_r),
    .ex_rfb        (ex_rfb),
    .ex_rf_waddr   (ex_rf_waddr),
    .ex_jalra      (ex_jalra),
    .ex_rt         (ex_rt),
    .wb_wdata      (wb_wdata),
    .wb_rfw        (wb_rfw),
    .wb_waddr      (wb_waddr),
    .bus           (bus),
    .mem_stall     (mem_stall),
    .bus_err       (bus_err),
    .p_c_rfw       (p_c_rfw),
    .p_c_wbsource  (p_c_wbsource),
    .p_alu_r       (p_alu_r),
    .p_mem_data    (p_mem_data),
    .p_rf_waddr    (p_rf_waddr),
    .p_jalra       (p_jalra)
  );

  typedef struct {
    logic        rfw;
    logic [1:0]  wbsrc;
    logic [31:0] alu_r;
    logic [31:0] mem;
    logic [4:0]  waddr;
    logic [31:0] jalra;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mdl_hold = '0;  // model of the load-data hold register
  logic [31:0] mdl_pmem = '0;  // model of p_mem_data
  logic [31:0] mdl_palu = '0;  // model of p_alu_r

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic [1:0] drw, input logic [31:0] a, input logic [31:0] rfb,
                          input logic [4:0] rt, input logic [4:0] wa, input logic [31:0] link);
    ex_c_drw      = drw;
    ex_alu_r      = a;
    ex_rfb        = rfb;
    ex_rt         = rt;
    ex_rf_waddr   = wa;
    ex_jalra      = link;
    ex_c_rfw      = !drw[0];
    ex_c_wbsource = drw[1] ? 2'd1 : 2'd2;
  endtask

  task automatic push_exp();
    exp_t e;
    e.rfw   = ex_c_rfw;
    e.wbsrc = ex_c_wbsource;
    e.alu_r = ex_alu_r;
    e.mem   = mdl_pmem;
    e.waddr = ex_rf_waddr;
    e.jalra = ex_jalra;
    sb_q.push_back(e);
  endtask

  task automatic check_p(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_p_rfw"}, 32'(p_c_rfw), 32'(e.rfw));
    check({tag, "_p_wbsrc"}, 32'(p_c_wbsource), 32'(e.wbsrc));
    check({tag, "_p_alu_r"}, p_alu_r, e.alu_r);
    check({tag, "_p_mem_data"}, p_mem_data, e.mem);
    check({tag, "_p_rf_waddr"}, 32'(p_rf_waddr), 32'(e.waddr));
    check({tag, "_p_jalra"}, p_jalra, e.jalra);
    mdl_palu = e.alu_r;
  endtask

  // Non-memory op; a stray bus_ack is held high to show it is ignored outside ACCESS.
  task automatic alu_op(input string tag, input logic [31:0] a, input logic [4:0] wa,
                        input logic [31:0] link);
    drive_ex(2'b00, a, 32'h0, 5'd0, wa, link);
    bus.bus_ack = 1'b1;
    #1;
    check({tag, "_stall"}, 32'(mem_stall), 32'd0);
    check({tag, "_req"}, 32'(bus.bus_req), 32'd0);
    push_exp();
    tick();
    bus.bus_ack = 1'b0;
    check({tag, "_req_after"}, 32'(bus.bus_req), 32'd0);
    check_p(tag);
  endtask

  // Memory op: ack_cyc = ACCESS cycle carrying bus_ack (0 = never), done_stall = cycles of
  // cpu_stall held in DONE.
  task automatic mem_access(input string tag, input logic [1:0] drw, input logic [31:0] a,
                            input logic [31:0] rfb, input logic [4:0] rt, input logic [4:0] wa,
                            input int ack_cyc, input logic [31:0] rdata, input int done_stall,
                            input int exp_stalls);
    int          stalls;
    logic [31:0] exp_wd;
    drive_ex(drw, a, rfb, rt, wa, 32'h0000_0100 + 32'(wa));
    exp_wd = (wb_rfw && (wb_waddr == rt) && (wb_waddr != 5'd0)) ? wb_wdata : rfb;
    if (ack_cyc == 0) mdl_hold = ErrData;
    else if (!drw[0]) mdl_hold = rdata;
    #1;
    stalls = 0;
    for (int i = 0; i < 50 && mem_stall; i++) begin
      stalls++;
      if (i == 1) begin
        check({tag, "_req"}, 32'(bus.bus_req), 32'd1);
        check({tag, "_addr"}, bus.bus_addr, {a[31:2], 2'b00});
        check({tag, "_we"}, 32'(bus.bus_we), 32'(drw[0]));
        check({tag, "_wdata"}, bus.bus_wdata, exp_wd);
      end
      if (ack_cyc != 0 && i == ack_cyc) begin
        bus.bus_ack   = 1'b1;
        bus.bus_rdata = rdata;
      end
      tick();
      bus.bus_ack   = 1'b0;
      bus.bus_rdata = 32'h0bad_0bad;
    end
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    check({tag, "_req_done"}, 32'(bus.bus_req), 32'd0);
    mdl_pmem = mdl_hold;
    push_exp();
    if (done_stall > 0) begin
      cpu_stall = 1'b1;
      for (int k = 0; k < done_stall; k++) begin
        tick();
        check({tag, "_hold_stall"}, 32'(mem_stall), 32'd0);
        check({tag, "_hold_req"}, 32'(bus.bus_req), 32'd0);
        check({tag, "_hold_p_alu"}, p_alu_r, mdl_palu);
      end
      cpu_stall = 1'b0;
    end
    tick();
    check_p(tag);
  endtask

  initial begin
    rst = 1'b1;
    cpu_stall = 1'b0;
    drive_ex(2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 32'h0);
    ex_c_rfw = 1'b0;
    ex_c_wbsource = 2'd0;
    wb_wdata = '0;
    wb_rfw = 1'b0;
    wb_waddr = '0;
    bus.bus_ack = 1'b0;
    bus.bus_rdata = '0;
    #2;
    check("rst_req", 32'(bus.bus_req), 32'd0);
    check("rst_we", 32'(bus.bus_we), 32'd0);
    check("rst_addr", bus.bus_addr, 32'd0);
    check("rst_wdata", bus.bus_wdata, 32'd0);
    check("rst_err", 32'(bus_err), 32'd0);
    check("rst_p_alu", p_alu_r, 32'd0);
    check("rst_p_mem", p_mem_data, 32'd0);
    check("rst_p_jalra", p_jalra, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();

    alu_op("alu7", 32'd7, 5'd3, 32'h44);
    mem_access("load", 2'b10, 32'h1000_0006, 32'h0, 5'd0, 5'd9, 2, 32'hcafe_f00d, 0, 3);
    alu_op("alu_after_load", 32'h1234_5678, 5'd4, 32'h48);

    wb_rfw = 1'b1;
    wb_waddr = 5'd5;
    wb_wdata = 32'h55;
    mem_access("st_fwd", 2'b01, 32'h2000_0010, 32'd1, 5'd5, 5'd0, 1, 32'h0, 0, 2);
    wb_waddr = 5'd0;
    mem_access("st_r0", 2'b01, 32'h2000_0014, 32'd1, 5'd5, 5'd0, 3, 32'h0, 0, 4);
    wb_rfw = 1'b0;
    mem_access("st_11", 2'b11, 32'h2000_0023, 32'h77, 5'd6, 5'd0, 1, 32'h0, 0, 2);

    mem_access("ld_stall", 2'b10, 32'h3000_0008, 32'h0, 5'd0, 5'd12, 1, 32'h0102_0304, 4, 2);
    check("err_default", 32'(bus_err), 32'd0);

`ifdef MEM_TIMEOUT_EN
    mem_access("tmo", 2'b10, 32'h4000_0000, 32'h0, 5'd0, 5'd13, 0, 32'h0, 0, 1 + TmoCycles);
    check("tmo_err", 32'(bus_err), 32'd1);
    alu_op("alu_after_tmo", 32'd9, 5'd14, 32'h50);
    check("tmo_err_sticky", 32'(bus_err), 32'd1);
`endif

    // Reset in the middle of an access.
    drive_ex(2'b10, 32'h5000_0000, 32'h0, 5'd0, 5'd15, 32'h60);
    tick();
    check("mid_req_before", 32'(bus.bus_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_req_async", 32'(bus.bus_req), 32'd0);
    check("mid_err_clear", 32'(bus_err), 32'd0);
    drive_ex(2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 32'h0);
    #2;
    rst = 1'b0;
    bus.bus_ack = 1'b1;
    bus.bus_rdata = 32'hffff_ffff;
    #1;
    check("mid_p_alu", p_alu_r, 32'd0);
    check("mid_p_mem", p_mem_data, 32'd0);
    tick();
    bus.bus_ack = 1'b0;
    check("mid_stray_req", 32'(bus.bus_req), 32'd0);
    check("mid_idle_stall", 32'(mem_stall), 32'd0);
    mdl_hold = '0;
    mdl_pmem = '0;
    mem_access("ld_after_rst", 2'b10, 32'h6000_000c, 32'h0, 5'd0, 5'd7, 1, 32'h0a0b_0c0d, 0, 2);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
